// File: rtl/trig_pkg.sv
// Shared types and constants for the memory-mapped trigger unit.
package trig_pkg;

  // FSM states; the encoding is visible to software through STAT[3:2].
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_FIRE  = 2'd3
  } state_t;

  // Word index (byte offset >> 2) of each register in the 32-byte window.
  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_STAT  = 3'd1;
  localparam logic [2:0] REG_DELAY = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_RAND  = 3'd4;

  // CTRL write bit positions.
  localparam int CTRL_ARM        = 0;
  localparam int CTRL_AUTO_REARM = 1;
  localparam int CTRL_CLEAR      = 2;
  localparam int CTRL_RAND_EN    = 3;

  // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mmio_trigger_unit_if.sv
// Data-memory port of the core as seen by a memory-mapped responder.
interface mmio_trigger_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  logic                     WE;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic [DATA_WIDTH-1:0]    RD;
  logic                     sel;

  // Core side issues loads/stores.
  modport master (output WE, A, WD, input RD, sel);
  // Responder side decodes and answers.
  modport slave (input WE, A, WD, output RD, sel);
endinterface

// File: rtl/trig_sync.sv
// Two-flop synchroniser for an asynchronous input plus rising-edge detect.
module trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift chain: metastability stage, synchronised stage, history stage.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Single-cycle strobe on a 0->1 transition of the synchronised input.
  assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/mmio_trigger_unit.sv
// Memory-mapped armed trigger: waits for an external edge, counts a
// programmable (optionally randomised) delay, then emits a one-cycle pulse.
module mmio_trigger_unit
  import trig_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                     DELAY_WIDTH   = 16,
  parameter int                     LFSR_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mmio_trigger_unit_if.slave  bus,
  input  logic                trigger_in,
  output logic                trigger_out,
  output logic                busy
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDRESS_WIDTH'(31);

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [DELAY_WIDTH-1:0] count_q, count_d;
  logic                   auto_rearm_q, auto_rearm_d;
  logic                   rand_en_q, rand_en_d;
  logic                   triggered_q, triggered_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;

  logic                     trig_rise;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [2:0]               word_idx;
  logic                     wr_en, ctrl_wr, delay_wr, clear_cmd, arm_cmd;
  logic [DELAY_WIDTH:0]     load_sum;
  logic [DELAY_WIDTH-1:0]   load_val;
  logic                     fire;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_bits;

  trig_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (trigger_in),
    .rise     (trig_rise)
  );

  // Address decode: window select and word index within the window.
  assign bus.sel  = (bus.A >= BASE_ADDR) && (bus.A <= LAST_ADDR);
  assign offset   = bus.A - BASE_ADDR;
  assign word_idx = offset[4:2];
  assign wr_en    = bus.WE & bus.sel;
  assign ctrl_wr  = wr_en && (word_idx == REG_CTRL);
  assign delay_wr = wr_en && (word_idx == REG_DELAY);
  assign clear_cmd = ctrl_wr & bus.WD[CTRL_CLEAR];
  assign arm_cmd   = ctrl_wr & bus.WD[CTRL_ARM];

  assign unused_bits = ^{offset[ADDRESS_WIDTH-1:5], offset[1:0], bus.WD[DATA_WIDTH-1:DELAY_WIDTH]};

  // Countdown load value: plain DELAY, or DELAY+RAND clamped to all-ones.
  always_comb begin
    load_sum = {1'b0, delay_q} + (DELAY_WIDTH+1)'(lfsr_q);
    load_val = delay_q;
    if (rand_en_q) begin
      load_val = load_sum[DELAY_WIDTH] ? {DELAY_WIDTH{1'b1}} : load_sum[DELAY_WIDTH-1:0];
    end
  end

  // FSM next-state and countdown; a clear command overrides every other outcome.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    fire        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_cmd) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_rise) begin
          state_d = ST_DELAY;
          count_d = load_val;
        end
      end
      ST_DELAY: begin
        if (count_q == '0) state_d = ST_FIRE;
        else               count_d = count_q - DELAY_WIDTH'(1);
      end
      ST_FIRE: begin
        fire        = 1'b1;
        triggered_d = 1'b1;
        state_d     = auto_rearm_q ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_cmd) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      triggered_d = 1'b0;
      fire        = 1'b0;
    end
  end

  // Software-visible configuration and the free-running random source.
  always_comb begin
    delay_d      = delay_wr ? bus.WD[DELAY_WIDTH-1:0] : delay_q;
    auto_rearm_d = ctrl_wr ? bus.WD[CTRL_AUTO_REARM] : auto_rearm_q;
    rand_en_d    = ctrl_wr ? bus.WD[CTRL_RAND_EN] : rand_en_q;
    lfsr_d       = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^
                   (lfsr_q[0] ? LFSR_WIDTH'(LFSR_TAPS) : '0);
  end

  // All unit state, cleared asynchronously; LFSR seeds to 1 so it never locks at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      delay_q      <= '0;
      count_q      <= '0;
      auto_rearm_q <= 1'b0;
      rand_en_q    <= 1'b0;
      triggered_q  <= 1'b0;
      lfsr_q       <= LFSR_WIDTH'(1);
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      count_q      <= count_d;
      auto_rearm_q <= auto_rearm_d;
      rand_en_q    <= rand_en_d;
      triggered_q  <= triggered_d;
      lfsr_q       <= lfsr_d;
    end
  end

  // Combinational load data; zero whenever the address is outside the window.
  always_comb begin
    rd_word = '0;
    if (bus.sel) begin
      case (word_idx)
        REG_CTRL:  rd_word = DATA_WIDTH'({rand_en_q, auto_rearm_q, 1'b0});
        REG_STAT:  rd_word = DATA_WIDTH'({2'(state_q), triggered_q, state_q == ST_ARMED});
        REG_DELAY: rd_word = DATA_WIDTH'(delay_q);
        REG_COUNT: rd_word = DATA_WIDTH'(count_q);
        REG_RAND:  rd_word = DATA_WIDTH'(lfsr_q);
        default:   rd_word = '0;
      endcase
    end
  end

  assign bus.RD      = rd_word;
  assign trigger_out = fire;
  assign busy        = (state_q != ST_IDLE);

endmodule
